fnd_source_arbiter: RTL and testbench

- Shares the single 8-digit multiplexed FND, driven by speed_fnd_controller, between three display sources: alert, speed/max-level, and gear/status.
- Selects one source and registers that source's packed 32-bit BCD word (8 nibbles, digit0 = bits[3:0]) onto value_out, which feeds speed_fnd_controller.value.
- Priority: alert preempts everything. Speed and gear rotate round-robin, each holding a minimum dwell time.

---
 rtl/fnd_source_arbiter_pkg.sv | 46 ++++
 rtl/fnd_source_arbiter_if.sv | 39 +++
 rtl/fnd_source_arbiter_dwell_timer.sv | 40 ++++
 rtl/fnd_source_arbiter.sv | 153 +++++++++++++++
 tb/tb_fnd_source_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_source_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fnd_arb_pkg
// Shared constants, types and helpers for the FND source arbiter.
//   - Source indices into the request vector (alert, speed, gear).
//   - One-hot grant encodings (3'b000 = idle).
//   - Arbiter FSM state enum and round-robin selector enum.
//   - IDLE_VALUE: word shown on the FND while nobody owns it.
// ---------------------------------------------------------------------------
package fnd_arb_pkg;

  localparam int SRC_ALERT = 0;
  localparam int SRC_SPEED = 1;
  localparam int SRC_GEAR  = 2;

  localparam logic [2:0] GRANT_NONE  = 3'b000;
  localparam logic [2:0] GRANT_ALERT = 3'b001;
  localparam logic [2:0] GRANT_SPEED = 3'b010;
  localparam logic [2:0] GRANT_GEAR  = 3'b100;

  localparam logic [31:0] IDLE_VALUE = 32'd0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OWN_ALERT  = 2'd1,
    OWN_ROTATE = 2'd2
  } arb_state_e;

  // Which of the two rotating sources is meant.
  typedef enum logic {
    RR_SPEED = 1'b0,
    RR_GEAR  = 1'b1
  } rr_sel_e;

  function automatic rr_sel_e rr_flip(input rr_sel_e s);
    return (s == RR_SPEED) ? RR_GEAR : RR_SPEED;
  endfunction

  function automatic logic [2:0] rr_grant(input rr_sel_e s);
    return (s == RR_GEAR) ? GRANT_GEAR : GRANT_SPEED;
  endfunction

  function automatic logic rr_req(input logic [2:0] req, input rr_sel_e s);
    return (s == RR_GEAR) ? req[SRC_GEAR] : req[SRC_SPEED];
  endfunction

endpackage

// File: rtl/fnd_source_arbiter_if.sv
// ---------------------------------------------------------------------------
// fnd_source_arbiter_if
// Bundles the arbiter's request/data inputs and display outputs.
//   req[2:0]      level request per source ([0] alert, [1] speed, [2] gear)
//   src0..2_value packed 32-bit BCD words from each source
//   value_out     registered word toward speed_fnd_controller.value
//   grant[2:0]    one-hot current owner, 000 = idle
//   switch_pulse  one-cycle pulse in the first cycle of a new grant
//   blank         1 = FND blanked (alert blink off-phase)
//   state_dbg     arbiter FSM state, for observation only
// Modports: master = source side (drives req/values), slave = arbiter.
//
// Handshake: there is no valid/ready pair. req is a level; a source owns the
// display exactly while its grant bit is 1, and the matching word appears on
// value_out one cycle after the grant bit rises. Sources never wait on an ack.
// ---------------------------------------------------------------------------
interface fnd_source_arbiter_if;
  import fnd_arb_pkg::*;

  logic [2:0]  req;
  logic [31:0] src0_value;
  logic [31:0] src1_value;
  logic [31:0] src2_value;
  logic [31:0] value_out;
  logic [2:0]  grant;
  logic        switch_pulse;
  logic        blank;
  arb_state_e  state_dbg;

  modport master (
    output req, src0_value, src1_value, src2_value,
    input  value_out, grant, switch_pulse, blank, state_dbg
  );

  modport slave (
    input  req, src0_value, src1_value, src2_value,
    output value_out, grant, switch_pulse, blank, state_dbg
  );
endinterface

// File: rtl/fnd_source_arbiter_dwell_timer.sv
// ---------------------------------------------------------------------------
// fnd_dwell_timer
// Terminal-count counter: counts 0..TERMINAL-1 while enable is high and wraps.
//   clk     rising-edge clock
//   rst     synchronous active-low reset (count -> 0)
//   clear   synchronous clear, wins over enable
//   enable  advance the count this cycle
//   tc      high while enabled at count TERMINAL-1 (combinational)
// ---------------------------------------------------------------------------
module fnd_dwell_timer #(
  parameter int unsigned TERMINAL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tc      = enable && (count_q == CW'(TERMINAL - 1));
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fnd_source_arbiter.sv
// ---------------------------------------------------------------------------
// fnd_source_arbiter
// Shares one 8-digit FND between alert, speed/max-level and gear/status.
// Alert preempts; speed and gear rotate round-robin with a minimum dwell of
// DWELL_CYCLES = CLK_FREQ/DWELL_HZ cycles each.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  fnd_source_arbiter_if.slave (req, src*_value in; value_out, grant,
//        switch_pulse, blank, state_dbg out)
// Optional feature macro: FND_ALERT_BLINK_EN -- while alert owns the display,
// blank toggles every DWELL_CYCLES/BLINK_DIV cycles. Without it blank is 0.
// ---------------------------------------------------------------------------
module fnd_source_arbiter
  import fnd_arb_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DWELL_HZ  = 1,
  parameter int BLINK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fnd_source_arbiter_if.slave  bus
);
  localparam int DWELL_CYCLES = CLK_FREQ / DWELL_HZ;

  // Reject configurations that cannot hold a meaningful dwell or blink.
  if (DWELL_CYCLES < 4) begin : g_bad_dwell
    $error("fnd_source_arbiter: DWELL_CYCLES must be >= 4");
  end
  if (BLINK_DIV < 1 || BLINK_DIV > DWELL_CYCLES) begin : g_bad_blink
    $error("fnd_source_arbiter: BLINK_DIV out of range");
  end

  arb_state_e  state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  rr_sel_e     rr_q, rr_d;
  logic [31:0] value_q, value_d;
  logic        pulse_q, pulse_d;
  logic        blank_q, blank_d;

  logic        dwell_tc;
  logic        dwell_clear;
  rr_sel_e     owner_sel, other_sel, resume_sel;
  logic        owner_req, other_req;

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;

    // Current rotating owner (only meaningful in OWN_ROTATE) and its peer.
    owner_sel  = (grant_q == GRANT_GEAR) ? RR_GEAR : RR_SPEED;
    other_sel  = rr_flip(owner_sel);
    owner_req  = rr_req(bus.req, owner_sel);
    other_req  = rr_req(bus.req, other_sel);
    // Where rotation starts from IDLE or after an alert.
    resume_sel = rr_req(bus.req, rr_q) ? rr_q : rr_flip(rr_q);

    if (bus.req == 3'b000) begin
      state_d = IDLE;
      grant_d = GRANT_NONE;
    end else if (bus.req[SRC_ALERT]) begin
      // Alert wins even on a dwell-expiry cycle; rr_q is left alone.
      state_d = OWN_ALERT;
      grant_d = GRANT_ALERT;
    end else begin
      unique case (state_q)
        OWN_ROTATE: begin
          // Owner released early, or dwell expired with the peer waiting.
          // A release with req != 0 and no alert implies the peer requests.
          if (!owner_req || (dwell_tc && other_req)) begin
            grant_d = rr_grant(other_sel);
            rr_d    = other_sel;
          end
        end
        default: begin
          state_d = OWN_ROTATE;
          grant_d = rr_grant(resume_sel);
          rr_d    = resume_sel;
        end
      endcase
    end

    pulse_d = (grant_d != grant_q);

    // value_out follows the owner registered last cycle, so data lags grant.
    unique case (grant_q)
      GRANT_ALERT: value_d = bus.src0_value;
      GRANT_SPEED: value_d = bus.src1_value;
      GRANT_GEAR:  value_d = bus.src2_value;
      default:     value_d = IDLE_VALUE;
    endcase
  end

  // Dwell restarts on every grant change so the new owner gets a full period.
  assign dwell_clear = (grant_d != grant_q) || (state_q != OWN_ROTATE);

  fnd_dwell_timer #(
    .TERMINAL (DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (dwell_clear),
    .enable (state_q == OWN_ROTATE),
    .tc     (dwell_tc)
  );

`ifdef FND_ALERT_BLINK_EN
  localparam int BLINK_CYCLES = DWELL_CYCLES / BLINK_DIV;
  logic blink_tc;

  fnd_dwell_timer #(
    .TERMINAL (BLINK_CYCLES)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_q != GRANT_ALERT),
    .enable (grant_q == GRANT_ALERT),
    .tc     (blink_tc)
  );

  // blink_tc is 0 on the entry cycle, so blank starts at 0 for each alert.
  assign blank_d = (grant_d == GRANT_ALERT) ? (blank_q ^ blink_tc) : 1'b0;
`else
  assign blank_d = 1'b0;
`endif

  // ----------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      rr_q    <= RR_SPEED;
      value_q <= IDLE_VALUE;
      pulse_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      value_q <= value_d;
      pulse_q <= pulse_d;
      blank_q <= blank_d;
    end
  end

  assign bus.value_out    = value_q;
  assign bus.grant        = grant_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.blank        = blank_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_fnd_source_arbiter.sv
module tb_fnd_source_arbiter;
  import fnd_arb_pkg::*;

  localparam int CLK_FREQ  = 16;
  localparam int DWELL_HZ  = 2;
  localparam int BLINK_DIV = 2;
  localparam int DWELL     = CLK_FREQ / DWELL_HZ;
  localparam int HALF      = DWELL / BLINK_DIV;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fnd_source_arbiter_if bus ();

  fnd_source_arbiter #(
    .CLK_FREQ  (CLK_FREQ),
    .DWELL_HZ  (DWELL_HZ),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  // --------------------------------------------------------- reference model
  // Owner codes: 0 nobody, 1 alert, 2 speed, 3 gear (request bit = owner-1).
  int          m_owner = 0;
  int          m_age   = 0;
  int          m_rr    = 2;
  int          m_bcnt  = 0;
  logic        m_pulse = 1'b0;
  logic        m_blank = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin : model
    int nxt;
    int oth;
    logic [31:0] shown;
    case (m_owner)
      1:       shown = bus.src0_value;
      2:       shown = bus.src1_value;
      3:       shown = bus.src2_value;
      default: shown = 32'd0;
    endcase
    if (!rst) begin
      m_owner = 0; m_age = 0; m_rr = 2; m_bcnt = 0;
      m_pulse = 1'b0; m_blank = 1'b0;
      exp_q.push_back(32'd0);
    end else begin
      oth = (m_owner == 2) ? 3 : 2;
      if (bus.req == 3'b000) nxt = 0;
      else if (bus.req[0]) nxt = 1;
      else if (m_owner >= 2) begin
        if (!bus.req[m_owner-1]) nxt = oth;
        else if (m_age == DWELL - 1 && bus.req[oth-1]) nxt = oth;
        else nxt = m_owner;
      end else begin
        nxt = bus.req[m_rr-1] ? m_rr : 5 - m_rr;
      end
      exp_q.push_back(shown);
      m_pulse = (nxt != m_owner);
`ifdef FND_ALERT_BLINK_EN
      if (nxt == 1 && m_owner == 1) begin
        m_bcnt++;
        if (m_bcnt == HALF) begin
          m_blank = ~m_blank;
          m_bcnt  = 0;
        end
      end else begin
        m_blank = 1'b0;
        m_bcnt  = 0;
      end
`else
      m_blank = 1'b0;
`endif
      m_age = (nxt != m_owner) ? 0 : (m_age + 1) % DWELL;
      if (nxt >= 2) m_rr = nxt;
      m_owner = nxt;
    end
  end

  // -------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [31:0] exp_v;
    logic [2:0]  exp_g;
    arb_state_e  exp_s;
    exp_g = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
    exp_s = (m_owner == 0) ? IDLE : (m_owner == 1) ? OWN_ALERT : OWN_ROTATE;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $error("FAIL exp_q_empty: observed %h expected a queued value", bus.value_out);
      exp_v = 32'd0;
    end else begin
      exp_v = exp_q.pop_front();
      chk("value_out", bus.value_out, exp_v);
    end
    chk("grant", 32'(bus.grant), 32'(exp_g));
    chk("switch_pulse", 32'(bus.switch_pulse), 32'(m_pulse));
    chk("blank", 32'(bus.blank), 32'(m_blank));
    chk("state", 32'(bus.state_dbg), 32'(exp_s));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input logic r, input logic [2:0] rq);
    rst     = r;
    bus.req = rq;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [2:0] rq;
    logic       rv;
    int         hold;
    bus.req        = 3'b000;
    bus.src0_value = 32'd0;
    bus.src1_value = 32'h73;
    bus.src2_value = 32'h2;

    // Reset and idle
    repeat (3) step(1'b0, 3'b000);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_value", bus.value_out, 32'd0);
    chk("rst_pulse", 32'(bus.switch_pulse), 32'd0);
    chk("rst_blank", 32'(bus.blank), 32'd0);

    // Rotation: speed 8 cycles, then gear 8 cycles, then speed again
    step(1'b1, 3'b110);
    chk("rot_first_grant", 32'(bus.grant), 32'(GRANT_SPEED));
    chk("rot_first_pulse", 32'(bus.switch_pulse), 32'd1);
    step(1'b1, 3'b110);
    chk("rot_speed_value", bus.value_out, 32'h73);
    repeat (6) step(1'b1, 3'b110);
    chk("rot_speed_last", 32'(bus.grant), 32'(GRANT_SPEED));
    step(1'b1, 3'b110);
    chk("rot_to_gear", 32'(bus.grant), 32'(GRANT_GEAR));
    chk("rot_gear_pulse", 32'(bus.switch_pulse), 32'd1);
    step(1'b1, 3'b110);
    chk("rot_gear_value", bus.value_out, 32'h2);
    repeat (6) step(1'b1, 3'b110);
    step(1'b1, 3'b110);
    chk("rot_back_speed", 32'(bus.grant), 32'(GRANT_SPEED));

    // Preemption at dwell count 3
    repeat (3) step(1'b1, 3'b110);
    bus.src0_value = 32'h9999;
    step(1'b1, 3'b111);
    chk("pre_grant", 32'(bus.grant), 32'(GRANT_ALERT));
    step(1'b1, 3'b111);
    chk("pre_value", bus.value_out, 32'h9999);
    repeat (3) step(1'b1, 3'b111);
`ifdef FND_ALERT_BLINK_EN
    chk("blink_on", 32'(bus.blank), 32'd1);
`else
    chk("blink_off", 32'(bus.blank), 32'd0);
`endif
    repeat (5) step(1'b1, 3'b111);
    step(1'b1, 3'b110);
    chk("pre_resume", 32'(bus.grant), 32'(GRANT_SPEED));
    repeat (7) step(1'b1, 3'b110);
    chk("pre_fresh_dwell", 32'(bus.grant), 32'(GRANT_SPEED));
    step(1'b1, 3'b110);
    chk("pre_after_dwell", 32'(bus.grant), 32'(GRANT_GEAR));

    // Single requester hold: one pulse at the initial grant only
    step(1'b1, 3'b010);
    chk("hold_first", 32'(bus.grant), 32'(GRANT_SPEED));
    repeat (29) begin
      step(1'b1, 3'b010);
      chk("hold_no_pulse", 32'(bus.switch_pulse), 32'd0);
    end
    chk("hold_grant", 32'(bus.grant), 32'(GRANT_SPEED));

    // Early release at dwell count 2
    repeat (5) step(1'b1, 3'b010);
    step(1'b1, 3'b100);
    chk("early_release", 32'(bus.grant), 32'(GRANT_GEAR));

    // Reset during alert, then fresh arbitration from speed
    step(1'b1, 3'b101);
    repeat (2) step(1'b1, 3'b101);
    step(1'b0, 3'b101);
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_value", bus.value_out, 32'd0);
    chk("midrst_blank", 32'(bus.blank), 32'd0);
    step(1'b1, 3'b110);
    chk("midrst_fresh", 32'(bus.grant), 32'(GRANT_SPEED));

    // Alert arriving on the dwell-expiry cycle: no rotation happens
    repeat (7) step(1'b1, 3'b110);
    step(1'b1, 3'b111);
    chk("tc_alert", 32'(bus.grant), 32'(GRANT_ALERT));
    step(1'b1, 3'b110);
    chk("tc_rr_kept", 32'(bus.grant), 32'(GRANT_SPEED));

    // All requests rising together from idle
    step(1'b1, 3'b000);
    step(1'b1, 3'b111);
    chk("all_rise", 32'(bus.grant), 32'(GRANT_ALERT));

    // Randomized traffic against the model
    repeat (500) begin
      rq   = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 14);
      repeat (hold) begin
        rv = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 3) == 0) bus.src0_value = $urandom;
        if ($urandom_range(0, 3) == 0) bus.src1_value = $urandom;
        if ($urandom_range(0, 3) == 0) bus.src2_value = $urandom;
        step(rv, rq);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
